// File: rtl/rf_wr_arb.sv
// Round-robin arbiter for the register file write port: two writeback requesters, registered output stage, x0 writes filtered.
// Optional macro RF_WR_ARB_FWD_EN adds combinational forwarding of the in-flight write onto two read ports.
module rf_wr_arb #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [4:0]       a_addr,
    input  logic [WIDTH-1:0] a_data,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [4:0]       b_addr,
    input  logic [WIDTH-1:0] b_data,
    output logic             we3,
    output logic [4:0]       wa3,
    output logic [WIDTH-1:0] wd3,
    output logic             conflict
`ifdef RF_WR_ARB_FWD_EN
    ,
    input  logic [4:0]       ra1,
    input  logic [4:0]       ra2,
    input  logic [WIDTH-1:0] rf_rd1,
    input  logic [WIDTH-1:0] rf_rd2,
    output logic [WIDTH-1:0] fwd_rd1,
    output logic [WIDTH-1:0] fwd_rd2
`endif
);

    typedef enum logic {
        GNT_A = 1'b0,
        GNT_B = 1'b1
    } gnt_e;

    gnt_e             last_gnt_reg, last_gnt_next;
    logic             we3_reg, we3_next;
    logic [4:0]       wa3_reg, wa3_next;
    logic [WIDTH-1:0] wd3_reg, wd3_next;
    logic             conflict_reg, conflict_next;
    logic             a_xfer, b_xfer;

    // Readiness looks only at the other requester, so a lone requester never waits.
    always_comb begin
        a_ready       = !b_valid || (last_gnt_reg == GNT_B);
        b_ready       = !a_valid || (last_gnt_reg == GNT_A);
        a_xfer        = a_valid && a_ready;
        b_xfer        = b_valid && b_ready && !a_xfer;
        last_gnt_next = last_gnt_reg;
        we3_next      = 1'b0;
        wa3_next      = wa3_reg;
        wd3_next      = wd3_reg;
        conflict_next = a_valid && b_valid;
        if (a_xfer) begin
            last_gnt_next = GNT_A;
            if (a_addr != 5'd0) begin
                we3_next = 1'b1;
                wa3_next = a_addr;
                wd3_next = a_data;
            end
        end else if (b_xfer) begin
            last_gnt_next = GNT_B;
            if (b_addr != 5'd0) begin
                we3_next = 1'b1;
                wa3_next = b_addr;
                wd3_next = b_data;
            end
        end
    end

    // Reset leaves last_gnt at B so that A wins the first contest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_reg <= GNT_B;
            we3_reg      <= 1'b0;
            wa3_reg      <= 5'd0;
            wd3_reg      <= '0;
            conflict_reg <= 1'b0;
        end else begin
            last_gnt_reg <= last_gnt_next;
            we3_reg      <= we3_next;
            wa3_reg      <= wa3_next;
            wd3_reg      <= wd3_next;
            conflict_reg <= conflict_next;
        end
    end

    assign we3      = we3_reg;
    assign wa3      = wa3_reg;
    assign wd3      = wd3_reg;
    assign conflict = conflict_reg;

`ifdef RF_WR_ARB_FWD_EN
    logic [4:0]       ra_arr  [2];
    logic [WIDTH-1:0] rd_arr  [2];
    logic [WIDTH-1:0] fwd_arr [2];

    assign ra_arr[0] = ra1;
    assign ra_arr[1] = ra2;
    assign rd_arr[0] = rf_rd1;
    assign rd_arr[1] = rf_rd2;

    // The register file has not captured the write yet during the cycle we3 is high.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwd_arr[gi] = (we3_reg && (wa3_reg == ra_arr[gi]) && (ra_arr[gi] != 5'd0))
                                 ? wd3_reg : rd_arr[gi];
        end
    endgenerate

    assign fwd_rd1 = fwd_arr[0];
    assign fwd_rd2 = fwd_arr[1];
`endif

endmodule
